w_stage_grf: RTL and testbench
==============================

// Module: w_stage_grf
// PURPOSE
//  Writeback-stage consumer of the MEM/WB pipeline register. Decodes the W-stage instruction, selects
//  and load-extends write data, and writes the 32x32 general register file. Provides two combinational
//  read ports to the D stage with internal write-to-read bypass. Exposes the writeback triple to the
//  hazard/forwarding unit.
// PARAMETERS
//  LINK_OFFSET  8  added to pc_w for the jal/jalr link value (delay-slot return address)
//  BYPASS_EN    1  1: a read of the register written this cycle returns the new data
// PORTS
//  clk      in   1   clock; all state updates on posedge
//  reset    in   1   synchronous, active-high; clears all 32 registers
//  instr_w  in   32  W-stage instruction (0 = nop bubble)
//  pc_w     in   32  W-stage PC
//  alu_w    in   32  W-stage ALU result; also the load byte address
//  dm_w     in   32  W-stage raw aligned data-memory word
//  ra1      in   5   read address, port 1 (rs)
//  ra2      in   5   read address, port 2 (rt)
//  rd1      out  32  read data, port 1
//  rd2      out  32  read data, port 2
//  wb_we    out  1   writeback enable this cycle (0 when wb_addr==0)
//  wb_addr  out  5   writeback destination
//  wb_data  out  32  writeback value
// BEHAVIOUR
//  - Reset: on posedge with reset=1, regs[0..31] <= 0. rd1 and rd2 then read 0, because they are
//    combinational over the cleared file. wb_* remain combinational from instr_w.
//  - Decode (combinational, opcode/funct from const.v):
//    addu/subu      -> rd, ALU
//    ori/lui        -> rt, ALU
//    lw/lb/lbu/lh/lhu -> rt, DM
//    jal            -> $31, PC+LINK_OFFSET
//    jalr           -> rd, PC+LINK_OFFSET
//    all others (sw, beq, j, jr, nop, unknown) -> no write
//  - wb_we = decoded_write && (wb_addr != 0). If wb_we=0: wb_addr=0 and wb_data=0.
//  - Load extension uses byte offset off=alu_w[1:0], little-endian:
//    lw           -> dm_w
//    lb / lbu     -> dm_w[8*off+7 : 8*off], sign- / zero-extended
//    lh / lhu     -> dm_w[16*off[1]+15 : 16*off[1]], sign- / zero-extended
//    Misaligned lw (off!=0) or lh/lhu (off[0]=1): the low offset bits are ignored; there is no trap.
//  - Write: at posedge, if !reset && wb_we, then regs[wb_addr] <= wb_data. Latency: 1 cycle to the
//    array, 0 cycles to the readers when BYPASS_EN=1.
//  - Read: rdN = (raN==0) ? 0
//                : (BYPASS_EN && wb_we && raN==wb_addr) ? wb_data
//                : regs[raN]
//    Both ports may hit the same register, or the register being written, in the same cycle.
//  - $0 always reads 0; writes to $0 never update the array.
//  - reset and wb_we high together: reset wins and no write occurs. Reads during the reset cycle still
//    follow the bypass rule (combinational).
//  - A bubble (instr_w=0 = sll $0,$0,0) decodes to "no write".
// STRUCTURE
//  - Opcode/funct encodings and the load-type enum (LD_W, LD_B, LD_BU, LD_H, LD_HU) go in shared const.v.
//  - Sub-module w_load_ext: (dm_w, off, ld_type) -> 32-bit extended data; purely combinational.
//  - Top level holds the decode logic, write-data mux, register array and bypass mux.
// TESTING
//  1. Reset, then read all 32 registers -> every rd1/rd2 = 0.
//  2. ori $5,$0,0x1234 (alu_w=0x1234), ra1=5 in the same cycle -> wb_we=1, wb_addr=5, rd1=0x1234
//     (bypass); next cycle, with a bubble in W, rd1 still = 0x1234.
//  3. Load extension, dm_w=0x8899AABB:
//     - lb,  alu_w=...1 -> 0xFFFFFFAA
//     - lbu, alu_w=...3 -> 0x00000088
//     - lh,  alu_w=...2 -> 0xFFFF8899
//     - lhu, alu_w=...0 -> 0x0000AABB
//     Each result is written to rt and read back.
//  4. jal with pc_w=0x00003000 -> $31=0x00003008. jalr rd=4 -> $4=0x00003008.
//  5. addu with rd=$0, alu_w=0xDEADBEEF, ra1=ra2=0 -> wb_we=0, rd1=rd2=0; $0 stays 0.
//  6. reset=1 together with a lui $7 write (0xABCD0000) -> after the edge $7 reads 0; sw and beq in W
//     -> wb_we=0 and no register changes.

Source files
------------

// File: rtl/w_stage_grf_pkg.sv
// Shared encodings and types for the writeback stage.
// Holds the opcode/funct values and the load-extension selector.
package w_stage_grf_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;

   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   typedef enum logic [2:0] {
      LD_W,
      LD_B,
      LD_BU,
      LD_H,
      LD_HU
   } ld_type_e;

   typedef enum logic [1:0] {
      SRC_ALU,
      SRC_DM,
      SRC_LINK
   } wb_src_e;

   function automatic ld_type_e ld_type_of(input logic [5:0] op);
      case (op)
         OP_LB:   return LD_B;
         OP_LBU:  return LD_BU;
         OP_LH:   return LD_H;
         OP_LHU:  return LD_HU;
         default: return LD_W;
      endcase
   endfunction

endpackage

// File: rtl/w_load_ext.sv
// Little-endian load extraction and sign/zero extension.
// Misaligned low offset bits are simply ignored for word/half.
module w_load_ext
   import w_stage_grf_pkg::*;
(
   input  logic [31:0] dm_w,
   input  logic [1:0]  off,
   input  ld_type_e    ld_type,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = dm_w[{off, 3'b000} +: 8];
      h = off[1] ? dm_w[31:16] : dm_w[15:0];
      case (ld_type)
         LD_B:    data = {{24{b[7]}}, b};
         LD_BU:   data = {24'd0, b};
         LD_H:    data = {{16{h[15]}}, h};
         LD_HU:   data = {16'd0, h};
         default: data = dm_w;
      endcase
   end

endmodule

// File: rtl/w_stage_grf.sv
// Writeback stage: decode, write-data select, 32x32 register file.
// Two combinational read ports see this cycle's write via bypass.
module w_stage_grf
   import w_stage_grf_pkg::*;
#(
   parameter int LINK_OFFSET = 8,
   parameter bit BYPASS_EN   = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_w,
   input  logic [31:0] pc_w,
   input  logic [31:0] alu_w,
   input  logic [31:0] dm_w,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data
);

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        is_r;
   logic        is_load;
   logic        dec_we;
   logic [4:0]  dst;
   wb_src_e     src;
   logic [31:0] ld_data;
   logic [31:0] link;
   logic [31:0] wr_data;
   logic        unused_instr;
   logic [31:0] regs [32];

   assign op      = instr_w[31:26];
   assign rt      = instr_w[20:16];
   assign rd      = instr_w[15:11];
   assign fn      = instr_w[5:0];
   assign is_r    = (op == OP_RTYPE);
   assign is_load = op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
   assign link    = pc_w + 32'(LINK_OFFSET);
   assign unused_instr = ^{instr_w[25:21], instr_w[10:6]};

   always_comb begin
      dec_we = 1'b0;
      dst    = rt;
      src    = SRC_ALU;
      unique case (1'b1)
         is_r && (fn == FN_ADDU || fn == FN_SUBU): begin
            dec_we = 1'b1;
            dst    = rd;
         end
         is_r && (fn == FN_JALR): begin
            dec_we = 1'b1;
            dst    = rd;
            src    = SRC_LINK;
         end
         (op == OP_ORI) || (op == OP_LUI): begin
            dec_we = 1'b1;
         end
         is_load: begin
            dec_we = 1'b1;
            src    = SRC_DM;
         end
         (op == OP_JAL): begin
            dec_we = 1'b1;
            dst    = 5'd31;
            src    = SRC_LINK;
         end
         default: ;
      endcase
   end

   w_load_ext u_ld (
      .dm_w    (dm_w),
      .off     (alu_w[1:0]),
      .ld_type (ld_type_of(op)),
      .data    (ld_data)
   );

   always_comb begin
      case (src)
         SRC_DM:   wr_data = ld_data;
         SRC_LINK: wr_data = link;
         default:  wr_data = alu_w;
      endcase
   end

   // Writes to $0 are squashed here so consumers never see them.
   assign wb_we   = dec_we && (dst != 5'd0);
   assign wb_addr = wb_we ? dst : 5'd0;
   assign wb_data = wb_we ? wr_data : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_we) begin
         regs[wb_addr] <= wb_data;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0
              : (BYPASS_EN && wb_we && ra1 == wb_addr) ? wb_data
              : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0
              : (BYPASS_EN && wb_we && ra2 == wb_addr) ? wb_data
              : regs[ra2];

endmodule

// File: tb/tb_w_stage_grf.sv
// Bench for w_stage_grf: directed cases then random traffic
// checked against an array-based register file model.
module tb_w_stage_grf;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_w, pc_w, alu_w, dm_w;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2, wb_data;
   logic        wb_we;
   logic [4:0]  wb_addr;

   int checks = 0;
   int errors = 0;
   logic [31:0] mregs [32];

   w_stage_grf dut (
      .clk     (clk),
      .reset   (reset),
      .instr_w (instr_w),
      .pc_w    (pc_w),
      .alu_w   (alu_w),
      .dm_w    (dm_w),
      .ra1     (ra1),
      .ra2     (ra2),
      .rd1     (rd1),
      .rd2     (rd2),
      .wb_we   (wb_we),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] fn,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Reference: what the stage should write, from the instruction table.
   task automatic model_wb(input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] alu, input logic [31:0] dm,
      output logic we, output logic [4:0] a, output logic [31:0] d);
      int unsigned off, v;
      bit wr;
      off = alu % 4;
      wr = 0; a = 0; d = 0;
      case (ins[31:26])
         6'h00: begin
            if (ins[5:0] == 6'h21 || ins[5:0] == 6'h23) begin
               wr = 1; a = ins[15:11]; d = alu;
            end else if (ins[5:0] == 6'h09) begin
               wr = 1; a = ins[15:11]; d = pc + 8;
            end
         end
         6'h0d, 6'h0f: begin wr = 1; a = ins[20:16]; d = alu; end
         6'h23: begin wr = 1; a = ins[20:16]; d = dm; end
         6'h20, 6'h24: begin
            wr = 1; a = ins[20:16];
            v = (dm >> (8 * off)) % 256;
            if (ins[31:26] == 6'h20 && v >= 128) v = v + 32'hFFFFFF00;
            d = v;
         end
         6'h21, 6'h25: begin
            wr = 1; a = ins[20:16];
            v = (dm >> (16 * (off / 2))) % 65536;
            if (ins[31:26] == 6'h21 && v >= 32768) v = v + 32'hFFFF0000;
            d = v;
         end
         6'h03: begin wr = 1; a = 31; d = pc + 8; end
         default: ;
      endcase
      we = wr && (a != 0);
      if (!we) begin a = 0; d = 0; end
   endtask

   function automatic logic [31:0] mread(input logic [4:0] ra, input logic we,
      input logic [4:0] a, input logic [31:0] d);
      if (ra == 0) return 0;
      if (we && ra == a) return d;
      return mregs[ra];
   endfunction

   task automatic step(input string tag, input logic rst,
      input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
      input logic [31:0] dm, input logic [4:0] r1, input logic [4:0] r2);
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      reset = rst; instr_w = ins; pc_w = pc; alu_w = alu; dm_w = dm;
      ra1 = r1; ra2 = r2;
      #1;
      model_wb(ins, pc, alu, dm, we, a, d);
      chk({tag, ".we"}, {31'd0, wb_we}, {31'd0, we});
      chk({tag, ".addr"}, {27'd0, wb_addr}, {27'd0, a});
      chk({tag, ".data"}, wb_data, d);
      chk({tag, ".rd1"}, rd1, mread(r1, we, a, d));
      chk({tag, ".rd2"}, rd2, mread(r2, we, a, d));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) mregs[i] = 0;
      end else if (we) begin
         mregs[a] = d;
      end
      @(negedge clk);
   endtask

   task automatic peek(input string tag, input logic [4:0] r,
                       input logic [31:0] exp);
      step({tag, ".bub"}, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, r, r);
      chk(tag, rd1, exp);
   endtask

   initial begin
      logic [31:0] ins, dmv;
      logic [4:0]  t, r1, r2;
      int k;
      for (int i = 0; i < 32; i++) mregs[i] = 0;
      reset = 1; instr_w = 0; pc_w = 0; alu_w = 0; dm_w = 0; ra1 = 0; ra2 = 0;
      @(negedge clk);
      step("rst", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);

      for (int i = 0; i < 32; i++)
         step($sformatf("rdall%0d", i), 1'b0, 32'd0, 32'd0, 32'd0, 32'd0,
              5'(i), 5'(31 - i));

      step("ori", 1'b0, itype(6'h0d, 0, 5, 16'h1234), 0, 32'h1234, 0, 5, 0);
      peek("ori_hold", 5, 32'h0000_1234);

      dmv = 32'h8899AABB;
      step("lb", 1'b0, itype(6'h20, 1, 8, 0), 0, 32'h0000_1001, dmv, 8, 0);
      peek("lb_rb", 8, 32'hFFFF_FFAA);
      step("lbu", 1'b0, itype(6'h24, 1, 9, 0), 0, 32'h0000_1003, dmv, 9, 0);
      peek("lbu_rb", 9, 32'h0000_0088);
      step("lh", 1'b0, itype(6'h21, 1, 10, 0), 0, 32'h0000_1002, dmv, 10, 0);
      peek("lh_rb", 10, 32'hFFFF_8899);
      step("lhu", 1'b0, itype(6'h25, 1, 11, 0), 0, 32'h0000_1000, dmv, 11, 0);
      peek("lhu_rb", 11, 32'h0000_AABB);

      step("jal", 1'b0, {6'h03, 26'h0000123}, 32'h3000, 0, 0, 31, 0);
      peek("jal_rb", 31, 32'h0000_3008);
      step("jalr", 1'b0, rtype(6'h09, 3, 0, 4), 32'h3000, 0, 0, 0, 4);
      peek("jalr_rb", 4, 32'h0000_3008);

      step("addu0", 1'b0, rtype(6'h21, 1, 2, 0), 0, 32'hDEADBEEF, 0, 0, 0);
      chk("addu0_we", {31'd0, wb_we}, 32'd0);

      step("rst_lui", 1'b1, itype(6'h0f, 0, 7, 16'hABCD), 0, 32'hABCD0000,
           0, 7, 5);
      peek("rst_lui_rb", 7, 32'd0);
      step("ori9", 1'b0, itype(6'h0d, 0, 9, 16'h77), 0, 32'h77, 0, 0, 0);
      step("sw", 1'b0, itype(6'h2b, 1, 9, 0), 0, 32'h5555, 32'h1, 9, 0);
      step("beq", 1'b0, itype(6'h04, 9, 9, 4), 0, 32'h6666, 0, 9, 9);
      peek("sw_beq_rb", 9, 32'h0000_0077);

      for (int n = 0; n < 400; n++) begin
         t = 5'($urandom_range(0, 31));
         k = $urandom_range(0, 13);
         case (k)
            0: ins = rtype(6'h21, 5'($urandom), 5'($urandom), t);
            1: ins = rtype(6'h23, 5'($urandom), 5'($urandom), t);
            2: ins = itype(6'h0d, 5'($urandom), t, 16'($urandom));
            3: ins = itype(6'h0f, 0, t, 16'($urandom));
            4: ins = itype(6'h23, 5'($urandom), t, 16'($urandom));
            5: ins = itype(6'h20, 5'($urandom), t, 16'($urandom));
            6: ins = itype(6'h24, 5'($urandom), t, 16'($urandom));
            7: ins = itype(6'h21, 5'($urandom), t, 16'($urandom));
            8: ins = itype(6'h25, 5'($urandom), t, 16'($urandom));
            9: begin ins = {6'h03, 26'($urandom)}; t = 31; end
            10: ins = rtype(6'h09, 5'($urandom), 0, t);
            11: ins = itype(6'h2b, 5'($urandom), t, 16'($urandom));
            12: ins = itype(6'h04, 5'($urandom), t, 16'($urandom));
            default: ins = ($urandom_range(0, 1) == 0) ? 32'd0 : {6'h3f, 26'($urandom)};
         endcase
         r1 = ($urandom_range(0, 1) == 0) ? t : 5'($urandom);
         r2 = ($urandom_range(0, 2) == 0) ? t : 5'($urandom);
         step($sformatf("rnd%0d", n), ($urandom_range(0, 49) == 0), ins,
              {$urandom, 2'b00} , $urandom, $urandom, r1, r2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
